lmk0482_ctrl: RTL

Power-up configuration sequencer for the LMK0482 clock distributor.
- Pulses the device RESET pin, then streams a table of 24-bit register words from an external ROM over the 3-wire SPI (write-only).
- Waits for PLL lock on STATUS_LD1/LD2, then issues a SYNC pulse.
- Sits between the board-level LMK0482 pins (SDIO tristate buffer is outside this block) and the system reset/bring-up logic.

---
 rtl/lmk0482_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lmk0482_ctrl.sv
// lmk0482_ctrl: LMK0482 bring-up sequencer -- device reset, SPI config load from ROM, lock wait, SYNC pulse
module lmk0482_ctrl #(
  parameter int CLK_DIV      = 4,
  parameter int RST_CYCLES   = 64,
  parameter int NWORDS       = 16,
  parameter int LOCK_CYCLES  = 256,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int SYNC_CYCLES  = 16,
  localparam int AW = NWORDS > 1 ? $clog2(NWORDS) : 1
) (
  input  logic          reset,
  input  logic          clk,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] rom_addr,
  output logic          rom_rd,
  input  logic [23:0]   rom_data,
  output logic          lmk0482_reset,
  output logic          lmk0482_sync,
  output logic          lmk0482_spi_cs_n,
  output logic          lmk0482_spi_sclk,
  output logic          lmk0482_spi_sdio_o,
  output logic          lmk0482_spi_sdio_oe,
  input  logic          lmk0482_status_ld1,
  input  logic          lmk0482_status_ld2
);
  localparam int CMAX = RST_CYCLES > CLK_DIV ? (RST_CYCLES > SYNC_CYCLES ? RST_CYCLES : SYNC_CYCLES)
                                             : (CLK_DIV > SYNC_CYCLES ? CLK_DIV : SYNC_CYCLES);
  localparam int CW = $clog2(CMAX + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(NWORDS - 1);
  localparam logic [LW-1:0] LOCK_N    = LW'(LOCK_CYCLES);
  localparam logic [TW-1:0] TMO_N     = TW'(LOCK_TIMEOUT);

  typedef enum logic [3:0] {IDLE, RST, FETCH, LOAD, SHIFT, GAP, LOCK_WAIT, SYNC, DONE, ERR} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    bit_idx, bit_idx_n;
  logic          phase, phase_n;
  logic [23:0]   shreg, shreg_n;
  logic [AW-1:0] addr_n;
  logic [LW-1:0] lock_cnt, lock_cnt_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic [1:0]    ld1_sync, ld2_sync;
  logic          locked, half_end;

  assign locked   = ld1_sync[1] & ld2_sync[1];
  assign half_end = cnt == DIV_LAST;

  always_comb begin
    state_n    = state;
    cnt_n      = '0;
    bit_idx_n  = bit_idx;
    phase_n    = phase;
    shreg_n    = shreg;
    addr_n     = rom_addr;
    lock_cnt_n = '0;
    tmo_cnt_n  = '0;
    case (state)
      IDLE, DONE, ERR: begin
        state_n = start ? RST : state;
        addr_n  = start ? '0 : rom_addr;
      end
      RST: begin
        state_n = cnt == RST_LAST ? FETCH : RST;
        cnt_n   = cnt == RST_LAST ? '0 : cnt + CW'(1);
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        shreg_n   = rom_data;
        bit_idx_n = '0;
        phase_n   = 1'b0;
        state_n   = SHIFT;
      end
      SHIFT: begin
        if (!half_end) cnt_n = cnt + CW'(1);
        else if (!phase) phase_n = 1'b1;
        else if (bit_idx == 5'd23) begin
          phase_n = 1'b0;
          state_n = GAP;
        end else begin
          phase_n   = 1'b0;
          bit_idx_n = bit_idx + 5'd1;
          shreg_n   = {shreg[22:0], 1'b0};
        end
      end
      GAP: begin
        if (!half_end) cnt_n = cnt + CW'(1);
        else if (rom_addr == ADDR_LAST) state_n = LOCK_WAIT;
        else begin
          addr_n  = rom_addr + AW'(1);
          state_n = FETCH;
        end
      end
      LOCK_WAIT: begin
        lock_cnt_n = locked ? lock_cnt + LW'(1) : '0;
        tmo_cnt_n  = tmo_cnt + TW'(1);
        state_n    = lock_cnt_n == LOCK_N ? SYNC : tmo_cnt_n == TMO_N ? ERR : LOCK_WAIT;
      end
      SYNC: begin
        state_n = cnt == SYNC_LAST ? DONE : SYNC;
        cnt_n   = cnt == SYNC_LAST ? '0 : cnt + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      bit_idx             <= '0;
      phase               <= 1'b0;
      shreg               <= '0;
      lock_cnt            <= '0;
      tmo_cnt             <= '0;
      ld1_sync            <= '0;
      ld2_sync            <= '0;
      rom_addr            <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
      rom_rd              <= 1'b0;
      lmk0482_reset       <= 1'b0;
      lmk0482_sync        <= 1'b0;
      lmk0482_spi_cs_n    <= 1'b1;
      lmk0482_spi_sclk    <= 1'b0;
      lmk0482_spi_sdio_o  <= 1'b0;
      lmk0482_spi_sdio_oe <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      bit_idx             <= bit_idx_n;
      phase               <= phase_n;
      shreg               <= shreg_n;
      lock_cnt            <= lock_cnt_n;
      tmo_cnt             <= tmo_cnt_n;
      ld1_sync            <= {ld1_sync[0], lmk0482_status_ld1};
      ld2_sync            <= {ld2_sync[0], lmk0482_status_ld2};
      rom_addr            <= addr_n;
      busy                <= !(state_n inside {IDLE, DONE, ERR});
      done                <= state_n == DONE;
      error               <= state_n == ERR;
      rom_rd              <= state_n == FETCH;
      lmk0482_reset       <= state_n == RST;
      lmk0482_sync        <= state_n == SYNC;
      lmk0482_spi_cs_n    <= state_n != SHIFT;
      lmk0482_spi_sclk    <= state_n == SHIFT && phase_n;
      lmk0482_spi_sdio_o  <= state_n == SHIFT && shreg_n[23];
      lmk0482_spi_sdio_oe <= state_n == SHIFT;
    end
endmodule
